// File: rtl/comb_lut_arbiter.sv
// comb_lut_arbiter
// Shares one combinational 4-in/6-out lookup unit between two round-robin
// requesters and a background sweep engine that walks every lookup input
// in otherwise idle cycles and accumulates an XOR checksum of the results.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no sweep; lookups only for client grants
// S_SWEEP | sweep active; cycles without a client grant step the counter
module comb_lut_arbiter #(
  parameter int IW = 4,
  parameter int OW = 6
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          req_a,
  input  logic [IW-1:0] idx_a,
  output logic          gnt_a,
  input  logic          req_b,
  input  logic [IW-1:0] idx_b,
  output logic          gnt_b,
  input  logic          sweep_start,
  output logic [IW-1:0] lut_i,
  input  logic [OW-1:0] lut_o,
  output logic          rsp_valid,
  output logic [1:0]    rsp_id,
  output logic [IW-1:0] rsp_idx,
  output logic [OW-1:0] rsp_data,
  output logic          busy,
  output logic          sweep_done,
  output logic [OW-1:0] sweep_xor
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  localparam logic [IW-1:0] CNT_LAST = '1;
  localparam logic [1:0]    ID_A     = 2'b00;
  localparam logic [1:0]    ID_B     = 2'b01;
  localparam logic [1:0]    ID_SWEEP = 2'b10;

  state_t        r_state;
  logic [IW-1:0] r_cnt;
  logic          r_lp_b;
  logic          r_done;
  logic [OW-1:0] r_xor;
  logic          r_rsp_valid;
  logic [1:0]    r_rsp_id;
  logic [IW-1:0] r_rsp_idx;
  logic [OW-1:0] r_rsp_data;

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_step;
  logic          w_lookup;
  logic [1:0]    w_id;
  logic [IW-1:0] w_lut_i;

  // Grant/steer decode. Gated by rst_b so the combinational outputs read
  // zero while reset is held, even with requests toggling.
  always_comb begin
    w_gnt_a = rst_b & req_a & (~req_b | r_lp_b);
    w_gnt_b = rst_b & req_b & (~req_a | ~r_lp_b);
    w_step  = rst_b & (r_state == S_SWEEP) & ~w_gnt_a & ~w_gnt_b;
    w_lookup = w_gnt_a | w_gnt_b | w_step;
    w_lut_i = '0;
    w_id    = ID_SWEEP;
    if (w_gnt_a) begin
      w_lut_i = idx_a;
      w_id    = ID_A;
    end else if (w_gnt_b) begin
      w_lut_i = idx_b;
      w_id    = ID_B;
    end else if (w_step) begin
      w_lut_i = r_cnt;
      w_id    = ID_SWEEP;
    end
  end

  // Sweep sequencer: state, step counter, checksum and done pulse.
  // sweep_start is only looked at in S_IDLE, so a pulse during the final
  // step is dropped rather than re-arming the sweep.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_xor   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sweep_start) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
            r_xor   <= '0;
          end
        end
        S_SWEEP: begin
          if (w_step) begin
            r_xor <= r_xor ^ lut_o;
            if (r_cnt == CNT_LAST) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Round-robin pointer: remembers the last client granted (1 = B).
  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_lp_b <= 1'b1;
    end else if (w_gnt_a) begin
      r_lp_b <= 1'b0;
    end else if (w_gnt_b) begin
      r_lp_b <= 1'b1;
    end
  end

  // Response register: one-cycle valid, idx/data hold between lookups.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_idx   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_lookup;
      if (w_lookup) begin
        r_rsp_id   <= w_id;
        r_rsp_idx  <= w_lut_i;
        r_rsp_data <= lut_o;
      end
    end
  end

  assign gnt_a      = w_gnt_a;
  assign gnt_b      = w_gnt_b;
  assign lut_i      = w_lut_i;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_idx    = r_rsp_idx;
  assign rsp_data   = r_rsp_data;
  assign busy       = (r_state == S_SWEEP);
  assign sweep_done = r_done;
  assign sweep_xor  = r_xor;

endmodule

// File: tb/tb_comb_lut_arbiter.sv
// Directed bench for comb_lut_arbiter; lookup unit modelled as 3*lut_i.
`timescale 1ns/1ps
module tb_comb_lut_arbiter;

  localparam int IW = 4;
  localparam int OW = 6;

  logic          clk;
  logic          rst_b;
  logic          req_a, req_b;
  logic [IW-1:0] idx_a, idx_b;
  logic          gnt_a, gnt_b;
  logic          sweep_start;
  logic [IW-1:0] lut_i;
  logic [OW-1:0] lut_o;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [IW-1:0] rsp_idx;
  logic [OW-1:0] rsp_data;
  logic          busy;
  logic          sweep_done;
  logic [OW-1:0] sweep_xor;

  int n_chk  = 0;
  int n_fail = 0;

  comb_lut_arbiter #(.IW(IW), .OW(OW)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_a       (req_a),
    .idx_a       (idx_a),
    .gnt_a       (gnt_a),
    .req_b       (req_b),
    .idx_b       (idx_b),
    .gnt_b       (gnt_b),
    .sweep_start (sweep_start),
    .lut_i       (lut_i),
    .lut_o       (lut_o),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_idx     (rsp_idx),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .sweep_xor   (sweep_xor)
  );

  always_comb lut_o = OW'(3 * int'(lut_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt_a"}, 32'(gnt_a), 0);
    chk({tag, ".gnt_b"}, 32'(gnt_b), 0);
    chk({tag, ".lut_i"}, 32'(lut_i), 0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".rsp_id"}, 32'(rsp_id), 0);
    chk({tag, ".rsp_idx"}, 32'(rsp_idx), 0);
    chk({tag, ".rsp_data"}, 32'(rsp_data), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".sweep_done"}, 32'(sweep_done), 0);
    chk({tag, ".sweep_xor"}, 32'(sweep_xor), 0);
  endtask

  // Full sweep with no clients; optionally pulses sweep_start mid-sweep and
  // in the final-step cycle, both of which must be ignored.
  task automatic do_sweep(input bit inject);
    sweep_start = 1'b1;
    #1;
    chk("sw.busy_at_start", 32'(busy), 0);
    tick();
    sweep_start = 1'b0;
    #1;
    chk("sw.busy_first", 32'(busy), 1);
    chk("sw.lut_i_first", 32'(lut_i), 0);
    chk("sw.rsp_valid_first", 32'(rsp_valid), 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("sw.rsp_valid", 32'(rsp_valid), 1);
      chk("sw.rsp_id", 32'(rsp_id), 2);
      chk("sw.rsp_idx", 32'(rsp_idx), 32'(i));
      chk("sw.rsp_data", 32'(rsp_data), 32'((3 * i) % 64));
      chk("sw.done", 32'(sweep_done), (i == 15) ? 1 : 0);
      chk("sw.busy", 32'(busy), (i == 15) ? 0 : 1);
      if (i == 15) chk("sw.xor", 32'(sweep_xor), 48);
      sweep_start = inject && (i == 5 || i == 14);
      tick();
    end
    sweep_start = 1'b0;
    #1;
    chk("sw.after.busy", 32'(busy), 0);
    chk("sw.after.done", 32'(sweep_done), 0);
    chk("sw.after.rsp_valid", 32'(rsp_valid), 0);
    chk("sw.after.xor_hold", 32'(sweep_xor), 48);
    chk("sw.after.idx_hold", 32'(rsp_idx), 15);
  endtask

  initial begin
    int sw_idx;
    int n_done;
    bit b_prev;

    rst_b = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    idx_a = '0;
    idx_b = '0;
    sweep_start = 1'b0;

    // Reset held with inputs toggling
    tick();
    req_a = 1'b1; req_b = 1'b0; sweep_start = 1'b1; idx_a = 4'd5;
    tick();
    req_a = 1'b0; req_b = 1'b1; sweep_start = 1'b0; idx_b = 4'd7;
    tick();
    req_a = 1'b1; req_b = 1'b1; sweep_start = 1'b1;
    #1;
    chk_all_zero("rst");
    req_a = 1'b0; req_b = 1'b0; sweep_start = 1'b0;
    #1;
    rst_b = 1'b1;
    tick();
    chk("idle.busy", 32'(busy), 0);
    chk("idle.lut_i", 32'(lut_i), 0);
    chk("idle.rsp_valid", 32'(rsp_valid), 0);

    // Contention: A first, then alternating
    for (int k = 0; k < 4; k++) begin
      req_a = 1'b1; idx_a = 4'd1;
      req_b = 1'b1; idx_b = 4'd2;
      #1;
      chk("cont.gnt_a", 32'(gnt_a), (k % 2 == 0) ? 1 : 0);
      chk("cont.gnt_b", 32'(gnt_b), (k % 2 == 0) ? 0 : 1);
      chk("cont.lut_i", 32'(lut_i), (k % 2 == 0) ? 1 : 2);
      if (k > 0) begin
        chk("cont.rsp_valid", 32'(rsp_valid), 1);
        chk("cont.rsp_id", 32'(rsp_id), ((k - 1) % 2 == 0) ? 0 : 1);
        chk("cont.rsp_data", 32'(rsp_data), ((k - 1) % 2 == 0) ? 3 : 6);
      end
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    #1;
    chk("cont.last.rsp_valid", 32'(rsp_valid), 1);
    chk("cont.last.rsp_id", 32'(rsp_id), 1);
    chk("cont.last.rsp_idx", 32'(rsp_idx), 2);
    chk("cont.last.rsp_data", 32'(rsp_data), 6);
    tick();
    chk("cont.idle.rsp_valid", 32'(rsp_valid), 0);
    chk("cont.idle.data_hold", 32'(rsp_data), 6);

    // Single A
    req_a = 1'b1; idx_a = 4'd5;
    #1;
    chk("singleA.gnt_a", 32'(gnt_a), 1);
    chk("singleA.gnt_b", 32'(gnt_b), 0);
    chk("singleA.lut_i", 32'(lut_i), 5);
    tick();
    req_a = 1'b0;
    #1;
    chk("singleA.rsp_valid", 32'(rsp_valid), 1);
    chk("singleA.rsp_id", 32'(rsp_id), 0);
    chk("singleA.rsp_idx", 32'(rsp_idx), 5);
    chk("singleA.rsp_data", 32'(rsp_data), 15);

    // Single B
    req_b = 1'b1; idx_b = 4'd9;
    #1;
    chk("singleB.gnt_b", 32'(gnt_b), 1);
    chk("singleB.gnt_a", 32'(gnt_a), 0);
    tick();
    req_b = 1'b0;
    #1;
    chk("singleB.rsp_id", 32'(rsp_id), 1);
    chk("singleB.rsp_idx", 32'(rsp_idx), 9);
    chk("singleB.rsp_data", 32'(rsp_data), 27);
    tick();
    chk("singleB.idle.rsp_valid", 32'(rsp_valid), 0);

    // Clean sweep with ignored restarts
    do_sweep(1'b1);
    tick();
    chk("post_sweep.busy", 32'(busy), 0);

    // Sweep stalled by B for three cycles starting with the idx-3 response
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    sw_idx = 0;
    idx_b = 4'd9;
    for (int cyc = 0; cyc < 19; cyc++) begin
      b_prev = (cyc >= 4 && cyc <= 6);
      chk("stall.rsp_valid", 32'(rsp_valid), 1);
      if (b_prev) begin
        chk("stall.b.rsp_id", 32'(rsp_id), 1);
        chk("stall.b.rsp_idx", 32'(rsp_idx), 9);
        chk("stall.b.rsp_data", 32'(rsp_data), 27);
      end else begin
        chk("stall.sw.rsp_id", 32'(rsp_id), 2);
        chk("stall.sw.rsp_idx", 32'(rsp_idx), 32'(sw_idx));
        chk("stall.sw.rsp_data", 32'(rsp_data), 32'((3 * sw_idx) % 64));
        sw_idx++;
      end
      chk("stall.done", 32'(sweep_done), (cyc == 18) ? 1 : 0);
      req_b = (cyc >= 3 && cyc <= 5);
      #1;
      chk("stall.gnt_b", 32'(gnt_b), (cyc >= 3 && cyc <= 5) ? 1 : 0);
      tick();
    end
    req_b = 1'b0;
    chk("stall.count", 32'(sw_idx), 16);
    chk("stall.busy_end", 32'(busy), 0);
    chk("stall.xor", 32'(sweep_xor), 48);

    // Reset in the middle of a sweep
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("mid.rsp_idx", 32'(rsp_idx), 32'(i));
      if (i < 7) tick();
    end
    chk("mid.busy_before", 32'(busy), 1);
    rst_b = 1'b0;
    #1;
    chk("mid.rst.busy", 32'(busy), 0);
    chk("mid.rst.rsp_valid", 32'(rsp_valid), 0);
    chk("mid.rst.xor", 32'(sweep_xor), 0);
    chk("mid.rst.rsp_data", 32'(rsp_data), 0);
    chk("mid.rst.lut_i", 32'(lut_i), 0);
    tick();
    chk("mid.rst.done", 32'(sweep_done), 0);
    rst_b = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sweep_done === 1'b1) n_done++;
    end
    chk("mid.no_done", 32'(n_done), 0);
    chk("mid.busy_idle", 32'(busy), 0);

    // Fresh sweep after the aborted one
    do_sweep(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
